// File: rtl/prime_pkg.sv
// Shared definitions for the sequential trial-division prime checker.
// Holds the controller state encoding and the legal operand-width range.
package prime_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/prime_checker_seq_rem_unit.sv
// Restoring remainder unit: one quotient bit per cycle, WIDTH cycles per division.
// done is a one-cycle registered pulse; remainder is valid while done is high.
module rem_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Shift the next dividend bit into the partial remainder, then try to subtract.
    assign trial = {rem_q, dvd_q[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs_q};

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        if (busy_q) begin
            rem_d = (trial >= {1'b0, dvs_q}) ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            dvd_d  = dividend;
            dvs_d  = divisor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done      = done_q;
    assign remainder = rem_q;

endmodule

// File: rtl/prime_checker_seq.sv
// Sequential primality test by trial division with 2, then odd divisors up to sqrt(N).
// Reports the smallest divisor above 1 for composites; ready/valid on both sides.
module prime_checker_seq
    import prime_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_prime,
    output logic [WIDTH-1:0] out_divisor
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("prime_checker_seq: WIDTH must lie in 2..16");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH:0]   d_q, d_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_prime_q, out_prime_d;
    logic [WIDTH-1:0] out_divisor_q, out_divisor_d;
    logic             rem_start;
    logic             rem_done;
    logic [WIDTH-1:0] rem_value;
    logic [2*WIDTH+1:0] d_sq;

    // Squared trial divisor kept wide enough that the compare against N cannot wrap.
    assign d_sq = {{(WIDTH+1){1'b0}}, d_q} * {{(WIDTH+1){1'b0}}, d_q};

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        d_d           = d_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_prime_d   = out_prime_q;
        out_divisor_d = out_divisor_q;
        rem_start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d        = in_value;
                    d_d        = (WIDTH+1)'(2);
                    in_ready_d = 1'b0;
                    state_d    = TEST;
                end
            end
            TEST: begin
                if (n_q < WIDTH'(2)) begin
                    out_valid_d   = 1'b1;
                    out_prime_d   = 1'b0;
                    out_divisor_d = '0;
                    state_d       = DONE;
                end else if (d_sq > {{(WIDTH+2){1'b0}}, n_q}) begin
                    out_valid_d   = 1'b1;
                    out_prime_d   = 1'b1;
                    out_divisor_d = '0;
                    state_d       = DONE;
                end else begin
                    rem_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (rem_done) begin
                    if (rem_value == '0) begin
                        out_valid_d   = 1'b1;
                        out_prime_d   = 1'b0;
                        out_divisor_d = d_q[WIDTH-1:0];
                        state_d       = DONE;
                    end else begin
                        d_d     = (d_q == (WIDTH+1)'(2)) ? (WIDTH+1)'(3) : d_q + (WIDTH+1)'(2);
                        state_d = TEST;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    out_prime_d   = 1'b0;
                    out_divisor_d = '0;
                    in_ready_d    = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            n_q           <= '0;
            d_q           <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_prime_q   <= 1'b0;
            out_divisor_q <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            d_q           <= d_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_prime_q   <= out_prime_d;
            out_divisor_q <= out_divisor_d;
        end
    end

    // Any trial divisor reaching DIV satisfies D*D <= N, so it fits in WIDTH bits.
    rem_unit #(
        .WIDTH(WIDTH)
    ) u_rem (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (rem_start),
        .dividend (n_q),
        .divisor  (d_q[WIDTH-1:0]),
        .done     (rem_done),
        .remainder(rem_value)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_prime   = out_prime_q;
    assign out_divisor = out_divisor_q;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Directed bench for prime_checker_seq: WIDTH=8 vector table plus handshake/reset
// sequences, and a WIDTH=3 instance swept over every operand.
module tb_prime_checker_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_prime8;
    logic [7:0] in_value8, out_divisor8;
    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_prime3;
    logic [2:0] in_value3, out_divisor3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prime_checker_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_value(in_value8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_prime(out_prime8), .out_divisor(out_divisor8)
    );

    prime_checker_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_value(in_value3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_prime(out_prime3), .out_divisor(out_divisor3)
    );

    typedef struct {
        logic [7:0] n;
        logic       prime;
        logic [7:0] divisor;
        int         lat;      // 0 = latency not checked
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operand on the WIDTH=8 instance with out_ready high; returns result and edge count.
    task automatic run8(input logic [7:0] n, output logic p, output logic [7:0] dv,
                        output int lat, output bit timed_out);
        in_value8  = n;
        in_valid8  = 1'b1;
        out_ready8 = 1'b1;
        lat        = 0;
        timed_out  = 1'b0;
        @(posedge clk); #1;
        lat       = 1;
        in_valid8 = 1'b0;
        in_value8 = 8'($urandom);
        while (!out_valid8 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = !out_valid8;
        p  = out_prime8;
        dv = out_divisor8;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t       vecs[18];
        logic       p;
        logic [7:0] dv;
        int         lat;
        bit         to;
        logic [7:0] exp3;

        vecs[0]  = '{8'd0,   1'b0, 8'd0,  2};
        vecs[1]  = '{8'd1,   1'b0, 8'd0,  2};
        vecs[2]  = '{8'd2,   1'b1, 8'd0,  2};
        vecs[3]  = '{8'd3,   1'b1, 8'd0,  2};
        vecs[4]  = '{8'd4,   1'b0, 8'd2,  0};
        vecs[5]  = '{8'd221, 1'b0, 8'd13, 0};
        vecs[6]  = '{8'd255, 1'b0, 8'd3,  0};
        vecs[7]  = '{8'd97,  1'b1, 8'd0,  52};
        vecs[8]  = '{8'd251, 1'b1, 8'd0,  82};
        vecs[9]  = '{8'd5,   1'b1, 8'd0,  12};
        vecs[10] = '{8'd7,   1'b1, 8'd0,  12};
        vecs[11] = '{8'd127, 1'b1, 8'd0,  62};
        vecs[12] = '{8'd25,  1'b0, 8'd5,  0};
        vecs[13] = '{8'd49,  1'b0, 8'd7,  0};
        vecs[14] = '{8'd169, 1'b0, 8'd13, 0};
        vecs[15] = '{8'd121, 1'b0, 8'd11, 0};
        vecs[16] = '{8'd253, 1'b0, 8'd11, 0};
        vecs[17] = '{8'd15,  1'b0, 8'd3,  0};

        rst_n      = 1'b0;
        in_valid8  = 1'b0; in_value8 = '0; out_ready8 = 1'b1;
        in_valid3  = 1'b0; in_value3 = '0; out_ready3 = 1'b1;
        #12;
        check("reset_in_ready",    32'(in_ready8),    32'd1);
        check("reset_out_valid",   32'(out_valid8),   32'd0);
        check("reset_out_prime",   32'(out_prime8),   32'd0);
        check("reset_out_divisor", 32'(out_divisor8), 32'd0);
        rst_n = 1'b1;
        #2;

        foreach (vecs[i]) begin
            check($sformatf("in_ready_before_n%0d", vecs[i].n), 32'(in_ready8), 32'd1);
            run8(vecs[i].n, p, dv, lat, to);
            $display("vec n=%0d prime=%0d divisor=%0d latency=%0d", vecs[i].n, p, dv, lat);
            check($sformatf("timeout_n%0d", vecs[i].n), 32'(to), 32'd0);
            check($sformatf("prime_n%0d", vecs[i].n), 32'(p), 32'(vecs[i].prime));
            check($sformatf("divisor_n%0d", vecs[i].n), 32'(dv), 32'(vecs[i].divisor));
            if (vecs[i].lat != 0)
                check($sformatf("latency_n%0d", vecs[i].n), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure with N=9 while spurious in_valid pulses arrive.
        out_ready8 = 1'b0;
        in_value8  = 8'd9;
        in_valid8  = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_timeout", 32'(out_valid8), 32'd1);
        for (int c = 0; c < 10; c++) begin
            in_valid8 = c[0];
            in_value8 = 8'd7 + 8'(c);
            @(posedge clk); #1;
            check($sformatf("bp_valid_c%0d", c),    32'(out_valid8),   32'd1);
            check($sformatf("bp_divisor_c%0d", c),  32'(out_divisor8), 32'd3);
            check($sformatf("bp_prime_c%0d", c),    32'(out_prime8),   32'd0);
            check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready8),    32'd0);
        end
        in_valid8  = 1'b0;
        $display("backpressure n=9 divisor=%0d held 10 cycles", out_divisor8);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid",    32'(out_valid8), 32'd0);
        check("bp_release_in_ready", 32'(in_ready8),  32'd1);
        run8(8'd5, p, dv, lat, to);
        $display("post-backpressure n=5 prime=%0d latency=%0d", p, lat);
        check("post_bp_timeout", 32'(to), 32'd0);
        check("post_bp_prime",   32'(p),  32'd1);

        // Asynchronous reset while a division of 143 is in flight.
        in_value8 = 8'd143;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",    32'(in_ready8),    32'd1);
        check("midrst_out_valid",   32'(out_valid8),   32'd0);
        check("midrst_out_prime",   32'(out_prime8),   32'd0);
        check("midrst_out_divisor", 32'(out_divisor8), 32'd0);
        #8;
        rst_n = 1'b1;
        #2;
        run8(8'd7, p, dv, lat, to);
        $display("after mid-division reset n=7 prime=%0d latency=%0d", p, lat);
        check("midrst_next_timeout", 32'(to),  32'd0);
        check("midrst_next_prime",   32'(p),   32'd1);
        check("midrst_next_latency", 32'(lat), 32'd12);

        // WIDTH=3 sweep: primes among 0..7 are 2, 3, 5, 7.
        exp3 = 8'b1010_1100;
        for (int n = 0; n < 8; n++) begin
            in_value3 = 3'(n);
            in_valid3 = 1'b1;
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            lat = 1;
            while (!out_valid3 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("w3 n=%0d prime=%0d divisor=%0d latency=%0d", n, out_prime3, out_divisor3, lat);
            check($sformatf("w3_timeout_n%0d", n), 32'(out_valid3), 32'd1);
            check($sformatf("w3_prime_n%0d", n),   32'(out_prime3), 32'(exp3[n]));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
